// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM states,
// requester indices, default data width and the rotating-priority pick.
package mux4_rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [1:0] REQ_0 = 2'd0;
   localparam logic [1:0] REQ_1 = 2'd1;
   localparam logic [1:0] REQ_2 = 2'd2;
   localparam logic [1:0] REQ_3 = 2'd3;

   localparam int N_DEFAULT = 16;

   // First set bit of req searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   // Scanning from the far end lets the nearest hit overwrite the result.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_pick = ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4to1.sv
// Plain 4:1 data multiplexer used for the arbiter's shared output port.
module Mux4to1
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic [N-1:0] in_c,
   input  logic [N-1:0] in_d,
   input  logic [1:0]   sel,
   output logic [N-1:0] out
);

   always_comb begin
      out = in_a;
      case (sel)
         REQ_0: out = in_a;
         REQ_1: out = in_b;
         REQ_2: out = in_c;
         REQ_3: out = in_d;
      endcase
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready port among four requesters,
// holding each grant until the owner's last beat or abandon. Optional stall
// timeout with forced release is enabled by defining ARB_TIMEOUT_EN.
module mux4_rr_arbiter
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int N = N_DEFAULT
`ifdef ARB_TIMEOUT_EN
   , parameter int TIMEOUT = 15
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   req,
   input  logic [3:0]   last,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic [N-1:0] in_c,
   input  logic [N-1:0] in_d,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [3:0]   grant,
   output logic [1:0]   slc,
   output logic         busy,
   output logic         timeout_err
);

   state_t     r_state;
   logic [3:0] r_grant;
   logic [1:0] r_slc;
   logic [1:0] r_ptr;
   logic       r_busy;

   logic [1:0] w_pick;
   logic       w_xfer;
   logic       w_release;

   assign w_pick    = rr_pick(req, r_ptr);
   assign out_valid = r_busy & req[r_slc];
   assign w_xfer    = out_valid & out_ready;
   // Normal release: final beat accepted, or the owner withdrew its request.
   assign w_release = (w_xfer & last[r_slc]) | ~req[r_slc];

   assign grant = r_grant;
   assign slc   = r_slc;
   assign busy  = r_busy;

   Mux4to1 #(.N(N)) u_mux (
      .in_a (in_a),
      .in_b (in_b),
      .in_c (in_c),
      .in_d (in_d),
      .sel  (r_slc),
      .out  (out_data)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int             CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);
   localparam logic [CW-1:0]  ONE  = CW'(1);

   logic [CW-1:0] r_cnt;
   logic          r_terr;
   logic          w_timeout;

   assign w_timeout   = (r_cnt == TMAX);
   assign timeout_err = r_terr;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_grant <= 4'b0000;
         r_slc   <= 2'd0;
         r_ptr   <= 2'd0;
         r_busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_cnt   <= '0;
         r_terr  <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         r_terr <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_state <= ST_GRANT;
                  r_slc   <= w_pick;
                  r_grant <= 4'b0001 << w_pick;
                  r_busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
               end
            end
            ST_GRANT: begin
               if (w_release) begin
                  r_state <= ST_IDLE;
                  r_grant <= 4'b0000;
                  r_busy  <= 1'b0;
                  r_ptr   <= r_slc + 2'd1;
               end
`ifdef ARB_TIMEOUT_EN
               // A last-beat release in the expiry cycle wins; no error then.
               else if (w_timeout) begin
                  r_state <= ST_IDLE;
                  r_grant <= 4'b0000;
                  r_busy  <= 1'b0;
                  r_ptr   <= r_slc + 2'd1;
                  r_terr  <= 1'b1;
               end else if (w_xfer) begin
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + ONE;
               end
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: constant vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a behavioural model.
module tb_mux4_rr_arbiter;
   import mux4_rr_arbiter_pkg::*;

   localparam int TB_TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, last;
   logic        out_ready;
   logic [15:0] din [4];
   logic        out_valid, busy, timeout_err;
   logic [15:0] out_data;
   logic [3:0]  grant;
   logic [1:0]  slc;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mux4_rr_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .last        (last),
      .in_a        (din[0]),
      .in_b        (din[1]),
      .in_c        (din[2]),
      .in_d        (din[3]),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .grant       (grant),
      .slc         (slc),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // Model: owner is -1 when idle, otherwise the index holding the port.
   int m_owner, m_ptr, m_slc, m_cnt;
   bit m_terr;

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_slc = 0; m_cnt = 0; m_terr = 0;
   endtask

   task automatic model_step();
      bit xfer;
      bit was_terr;
      was_terr = 0;
      if (m_owner < 0) begin
         for (int off = 0; off < 4; off++) begin
            int i;
            i = (m_ptr + off) % 4;
            if (req[i]) begin
               m_owner = i; m_slc = i; m_cnt = 0;
               break;
            end
         end
      end else begin
         xfer = req[m_owner] && out_ready;
         if ((xfer && last[m_owner]) || !req[m_owner]) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1;
         end
`ifdef ARB_TIMEOUT_EN
         else if (m_cnt == TB_TIMEOUT) begin
            m_ptr = (m_owner + 1) % 4; m_owner = -1; was_terr = 1;
         end else if (xfer) m_cnt = 0;
         else m_cnt++;
`endif
      end
      m_terr = was_terr;
   endtask

   function automatic logic [24:0] dut_pack();
      return {grant, slc, busy, out_valid, timeout_err, out_data};
   endfunction

   function automatic logic [24:0] model_pack();
      logic [3:0] g;
      logic       v;
      g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      v = (m_owner >= 0) && req[m_slc];
      return {g, 2'(m_slc), (m_owner >= 0), v, m_terr, din[m_slc]};
   endfunction

   task automatic check(input string nm, input logic [24:0] act, input logic [24:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (grant,slc,busy,valid,terr,data)", nm, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Called at a negedge with inputs already driven.
   task automatic tick(input string nm);
      #1;
      check(nm, dut_pack(), model_pack());
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 4'b0; last = 4'b0; out_ready = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct packed {
      logic [3:0]  req;
      logic [3:0]  last;
      logic        rdy;
      logic [3:0]  grant;
      logic [1:0]  slc;
      logic        busy;
      logic        valid;
      logic [15:0] data;
   } vec_t;

   vec_t vecs [14];

   initial begin
      int hold, beats, pulses;

      vecs[0]  = '{4'b0100, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 16'h1111};
      vecs[1]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 16'hA5A5};
      vecs[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 16'hA5A5};
      vecs[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 16'hA5A5};
      vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 16'h4444};
      vecs[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 16'h4444};
      vecs[6]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 16'h1111};
      vecs[7]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 16'h1111};
      vecs[8]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 16'h2222};
      vecs[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 16'h2222};
      vecs[10] = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 16'hA5A5};
      vecs[11] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 16'hA5A5};
      vecs[12] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 16'h4444};
      vecs[13] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 16'h4444};

      din[0] = 16'h1111; din[1] = 16'h2222; din[2] = 16'hA5A5; din[3] = 16'h4444;
      do_reset();

      // Single grant to requester 2, then round-robin wrap from ptr=3.
      for (int i = 0; i < 14; i++) begin
         req = vecs[i].req; last = vecs[i].last; out_ready = vecs[i].rdy;
         #1;
         check($sformatf("vec%0d", i), {grant, slc, busy, out_valid, timeout_err, out_data},
               {vecs[i].grant, vecs[i].slc, vecs[i].busy, vecs[i].valid, 1'b0, vecs[i].data});
         @(posedge clk); @(negedge clk);
      end

      // Multi-beat: 3 stalls, then 4 beats with last on the 4th.
      do_reset();
      hold = 0; beats = 0;
      for (int c = 0; c < 10; c++) begin
         req = (c <= 7) ? 4'b0001 : 4'b0000;
         out_ready = (c >= 4);
         last = (c == 7) ? 4'b0001 : 4'b0000;
         din[0] = 16'($urandom);
         #1;
         if (grant == 4'b0001) hold++;
         if (grant == 4'b0001 && out_valid && out_ready) beats++;
         tick($sformatf("multibeat_c%0d", c));
      end
      check_int("multibeat_hold", hold, 7);
      check_int("multibeat_beats", beats, 4);

      // Owner 1 abandons; pending requester 3 gets the next grant.
      do_reset();
      out_ready = 1'b0; last = 4'b0000;
      req = 4'b0010; tick("abandon_idle");
      req = 4'b1010; tick("abandon_own1");
      req = 4'b1000; tick("abandon_drop");
      tick("abandon_gap");
      tick("abandon_own3");

      // Asynchronous reset in the middle of a transfer.
      do_reset();
      req = 4'b1000; last = 4'b0000; out_ready = 1'b1;
      tick("rst_seq_idle");
      #2; rst = 1'b1; #1;
      check("rst_async", {grant, slc, busy, out_valid, timeout_err, out_data},
            {4'b0000, REQ_0, 1'b0, 1'b0, 1'b0, din[0]});
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1001; last = 4'b1001;
      for (int c = 0; c < 4; c++) tick($sformatf("rst_after_c%0d", c));

`ifdef ARB_TIMEOUT_EN
      // Owner 0 stalls until forced release; requester 1 follows.
      do_reset();
      req = 4'b0011; last = 4'b0000; out_ready = 1'b0;
      pulses = 0;
      for (int c = 0; c < 25; c++) begin
         #1;
         if (timeout_err) pulses++;
         tick($sformatf("timeout_c%0d", c));
      end
      check_int("timeout_pulses", pulses, 1);
`else
      pulses = 0;
`endif

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req = 4'($urandom_range(0, 15));
         last = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 4; i++) din[i] = 16'($urandom);
         tick($sformatf("rand_c%0d", c));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
